// File: rtl/reaction_timer_multi.sv
// -----------------------------------------------------------------------------
// reaction_timer_multi
//
// Multi-player reaction timer. A round starts from IDLE/DONE on a start pulse,
// waits a pseudo-random armed delay (MIN_DELAY + masked LFSR, in ticks), then
// raises go and measures each player's reaction in ticks. Presses during ARM
// are fouls. The GO phase ends when every player has a result or when elapsed
// reaches TIMEOUT. The first valid press cycle decides winner/tie, and the best
// winning time is kept across rounds until reset.
//
// Ports:
//   clk        system clock
//   clear      asynchronous active-low reset
//   start      round request, asynchronous to clk
//   press      player buttons [PLAYERS], asynchronous to clk
//   go         high during the GO phase
//   state      0=IDLE 1=ARM 2=GO 3=DONE
//   result     per-player reaction time, player p at [p*TIME_W +: TIME_W]
//   done       player has a final result this round
//   foul       player pressed during ARM
//   winner     one-hot fastest valid player
//   win_valid  winner is meaningful
//   tie        several players pressed on the winning cycle
//   best       fastest winning time since reset (all-ones = none yet)
// -----------------------------------------------------------------------------
module reaction_timer_multi #(
    parameter int unsigned PLAYERS    = 2,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned TIME_W     = 10,
    parameter int unsigned TIMEOUT    = 999,
    parameter int unsigned MIN_DELAY  = 1000,
    parameter logic [15:0] DELAY_MASK = 16'h0FFF
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic                      start,
    input  logic [PLAYERS-1:0]        press,
    output logic                      go,
    output logic [1:0]                state,
    output logic [PLAYERS*TIME_W-1:0] result,
    output logic [PLAYERS-1:0]        done,
    output logic [PLAYERS-1:0]        foul,
    output logic [PLAYERS-1:0]        winner,
    output logic                      win_valid,
    output logic                      tie,
    output logic [TIME_W-1:0]         best
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DLY_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GO   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Lowest set bit of a press vector (lowest-index player wins ties).
    function automatic logic [PLAYERS-1:0] f_lowest_one(input logic [PLAYERS-1:0] v);
        return v & (~v + PLAYERS'(1));
    endfunction

    // True when two or more bits of the vector are set.
    function automatic logic f_multi_hot(input logic [PLAYERS-1:0] v);
        return |(v & (v - PLAYERS'(1)));
    endfunction

    state_t                    r_state;
    logic                      r_go;
    logic [PLAYERS*TIME_W-1:0] r_result;
    logic [PLAYERS-1:0]        r_done;
    logic [PLAYERS-1:0]        r_foul;
    logic [PLAYERS-1:0]        r_winner;
    logic                      r_win_valid;
    logic                      r_tie;
    logic [TIME_W-1:0]         r_best;
    logic [TIME_W-1:0]         r_win_time;
    logic [TIME_W-1:0]         r_elapsed;
    logic [DLY_W-1:0]          r_delay;
    logic [PRE_W-1:0]          r_pre;
    logic [15:0]               r_lfsr;

    logic                      r_start_meta;
    logic                      r_start_sync;
    logic                      r_start_prev;
    logic [PLAYERS-1:0]        r_press_meta;
    logic [PLAYERS-1:0]        r_press_sync;
    logic [PLAYERS-1:0]        r_press_prev;

    logic                      w_start_pulse;
    logic [PLAYERS-1:0]        w_press_pulse;
    logic [PLAYERS-1:0]        w_press_valid;
    logic [PLAYERS-1:0]        w_done_next;
    logic                      w_all_done;
    logic                      w_tick;
    logic                      w_timeout;
    logic                      w_first;
    logic                      w_win_valid_n;
    logic [TIME_W-1:0]         w_win_time_n;
    logic                      w_lfsr_fb;

    assign go        = r_go;
    assign state     = r_state;
    assign result    = r_result;
    assign done      = r_done;
    assign foul      = r_foul;
    assign winner    = r_winner;
    assign win_valid = r_win_valid;
    assign tie       = r_tie;
    assign best      = r_best;

    // Rising edges of the synchronised inputs; a held input gives one pulse.
    assign w_start_pulse = r_start_sync & ~r_start_prev;
    assign w_press_pulse = r_press_sync & ~r_press_prev;

    // Only players without a final result can register a press.
    assign w_press_valid = w_press_pulse & ~r_done;
    assign w_done_next   = r_done | w_press_valid;
    assign w_all_done    = &w_done_next;

    assign w_tick    = (r_pre == PRE_W'(TICK_DIV - 1));
    // The tick that would move elapsed onto TIMEOUT ends the GO phase.
    assign w_timeout = w_tick && (r_elapsed == TIME_W'(TIMEOUT - 1));

    // Winner bookkeeping as it will stand after this cycle; used for best.
    assign w_first       = (|w_press_valid) & ~r_win_valid;
    assign w_win_valid_n = r_win_valid | w_first;
    assign w_win_time_n  = w_first ? r_elapsed : r_win_time;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Two-flop synchronisers plus previous-value flops for edge detection.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_start_meta <= 1'b0;
            r_start_sync <= 1'b0;
            r_start_prev <= 1'b0;
            r_press_meta <= '0;
            r_press_sync <= '0;
            r_press_prev <= '0;
        end else begin
            r_start_meta <= start;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
            r_press_meta <= press;
            r_press_sync <= r_press_meta;
            r_press_prev <= r_press_sync;
        end
    end

    // Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // Round FSM with tick prescaler, delay/elapsed counters and result capture.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state     <= ST_IDLE;
            r_go        <= 1'b0;
            r_result    <= '0;
            r_done      <= '0;
            r_foul      <= '0;
            r_winner    <= '0;
            r_win_valid <= 1'b0;
            r_tie       <= 1'b0;
            r_best      <= '1;
            r_win_time  <= '0;
            r_elapsed   <= '0;
            r_delay     <= '0;
            r_pre       <= '0;
        end else begin
            // Prescaler wraps on its own; ARM/GO entry below restarts it.
            if (w_tick) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_pulse) begin
                        r_state     <= ST_ARM;
                        r_pre       <= '0;
                        r_delay     <= DLY_W'(MIN_DELAY) + DLY_W'(r_lfsr & DELAY_MASK);
                        r_result    <= '0;
                        r_done      <= '0;
                        r_foul      <= '0;
                        r_winner    <= '0;
                        r_win_valid <= 1'b0;
                        r_tie       <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end

                ST_ARM: begin
                    for (int p = 0; p < PLAYERS; p++) begin
                        if (w_press_valid[p]) begin
                            r_result[p*TIME_W +: TIME_W] <= '1;
                        end else begin
                            r_result[p*TIME_W +: TIME_W] <= r_result[p*TIME_W +: TIME_W];
                        end
                    end
                    r_foul <= r_foul | w_press_valid;
                    r_done <= w_done_next;
                    // Everyone fouled: the round ends without go ever rising.
                    if (w_all_done) begin
                        r_state <= ST_DONE;
                    end else if (w_tick) begin
                        if (r_delay == DLY_W'(1)) begin
                            r_state   <= ST_GO;
                            r_go      <= 1'b1;
                            r_elapsed <= '0;
                            r_pre     <= '0;
                        end else begin
                            r_delay <= r_delay - DLY_W'(1);
                        end
                    end else begin
                        r_state <= ST_ARM;
                    end
                end

                ST_GO: begin
                    // Presses capture the pre-increment elapsed value.
                    for (int p = 0; p < PLAYERS; p++) begin
                        if (w_press_valid[p]) begin
                            r_result[p*TIME_W +: TIME_W] <= r_elapsed;
                        end else if (w_timeout && !r_done[p]) begin
                            r_result[p*TIME_W +: TIME_W] <= TIME_W'(TIMEOUT);
                        end else begin
                            r_result[p*TIME_W +: TIME_W] <= r_result[p*TIME_W +: TIME_W];
                        end
                    end
                    if (w_tick) begin
                        r_elapsed <= r_elapsed + TIME_W'(1);
                    end else begin
                        r_elapsed <= r_elapsed;
                    end
                    if (w_first) begin
                        r_winner    <= f_lowest_one(w_press_valid);
                        r_win_valid <= 1'b1;
                        r_tie       <= f_multi_hot(w_press_valid);
                        r_win_time  <= r_elapsed;
                    end else begin
                        r_win_time  <= r_win_time;
                    end
                    if (w_all_done || w_timeout) begin
                        r_state <= ST_DONE;
                        r_go    <= 1'b0;
                        r_done  <= w_timeout ? '1 : w_done_next;
                        if (w_win_valid_n && (w_win_time_n < r_best)) begin
                            r_best <= w_win_time_n;
                        end else begin
                            r_best <= r_best;
                        end
                    end else begin
                        r_done <= w_done_next;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_go    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer_multi.sv
// -----------------------------------------------------------------------------
// Self-checking bench for reaction_timer_multi with small timing parameters:
// TICK_DIV=4, MIN_DELAY=3, DELAY_MASK=0, TIMEOUT=20, PLAYERS=2, TIME_W=10.
// With these, go rises 12 clk after ARM entry and a press raised 4k-1 clk
// after GO entry is acted on 3 clk later, while elapsed still reads k.
// -----------------------------------------------------------------------------
module tb_reaction_timer_multi;

    logic        clk   = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  press = 2'b00;
    logic        go;
    logic [1:0]  state;
    logic [19:0] result;
    logic [1:0]  done;
    logic [1:0]  foul;
    logic [1:0]  winner;
    logic        win_valid;
    logic        tie;
    logic [9:0]  best;

    int n_checks = 0;
    int n_fail   = 0;
    int g_cnt    = 0;
    int lat      = 0;

    typedef struct {
        int         k0;
        int         k1;
        bit         inj;
        logic [9:0] r0;
        logic [9:0] r1;
        logic [1:0] win;
        logic       tie;
        logic [9:0] best;
    } round_t;

    round_t rounds[5];

    reaction_timer_multi #(
        .PLAYERS    (2),
        .TICK_DIV   (4),
        .TIME_W     (10),
        .TIMEOUT    (20),
        .MIN_DELAY  (3),
        .DELAY_MASK (16'h0000)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .start     (start),
        .press     (press),
        .go        (go),
        .state     (state),
        .result    (result),
        .done      (done),
        .foul      (foul),
        .winner    (winner),
        .win_valid (win_valid),
        .tie       (tie),
        .best      (best)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},  state,     32'd0);
        check({tag, "_go"},     go,        32'd0);
        check({tag, "_result"}, result,    32'd0);
        check({tag, "_done"},   done,      32'd0);
        check({tag, "_foul"},   foul,      32'd0);
        check({tag, "_winner"}, winner,    32'd0);
        check({tag, "_winv"},   win_valid, 32'd0);
        check({tag, "_tie"},    tie,       32'd0);
        check({tag, "_best"},   best,      32'h3FF);
    endtask

    // Raise start and wait for ARM; start is acted on 3 clk after it rises.
    task automatic begin_round(input bit hold);
        int cnt;
        cnt = 0;
        start = 1'b1;
        while (cnt < 10 && state !== 2'd1) begin
            step(1);
            cnt++;
        end
        check("start_latency", cnt, 32'd3);
        if (!hold) start = 1'b0;
    endtask

    // Count clk until go rises, bounded.
    task automatic wait_go(output int cnt);
        cnt = 0;
        while (cnt < 200 && go !== 1'b1) begin
            step(1);
            cnt++;
        end
        g_cnt = 0;
    endtask

    // Press so that the DUT registers it while elapsed == k.
    task automatic press_at(input logic [1:0] mask, input int k);
        int tgt;
        tgt = 4 * k - 1;
        if (tgt > g_cnt) step(tgt - g_cnt);
        press = press | mask;
        step(3);
        press = press & ~mask;
        g_cnt = tgt + 3;
    endtask

    task automatic run_round(input int idx);
        round_t r;
        r = rounds[idx];
        begin_round(1'b0);
        if (r.inj) begin
            step(2);
            start = 1'b1;
            step(3);
            start = 1'b0;
            wait_go(lat);
            check($sformatf("r%0d_arm_start_ignored", idx), lat, 32'd7);
            start = 1'b1;
            step(3);
            start = 1'b0;
            g_cnt = 3;
        end else begin
            wait_go(lat);
            check($sformatf("r%0d_go_latency", idx), lat, 32'd12);
        end
        if (r.k0 == r.k1) begin
            press_at(2'b11, r.k0);
        end else if (r.k0 < r.k1) begin
            press_at(2'b01, r.k0);
            press_at(2'b10, r.k1);
        end else begin
            press_at(2'b10, r.k1);
            press_at(2'b01, r.k0);
        end
        check($sformatf("r%0d_state", idx),  state,         32'd3);
        check($sformatf("r%0d_go", idx),     go,            32'd0);
        check($sformatf("r%0d_res0", idx),   result[9:0],   r.r0);
        check($sformatf("r%0d_res1", idx),   result[19:10], r.r1);
        check($sformatf("r%0d_winner", idx), winner,        r.win);
        check($sformatf("r%0d_winv", idx),   win_valid,     32'd1);
        check($sformatf("r%0d_tie", idx),    tie,           r.tie);
        check($sformatf("r%0d_done", idx),   done,          32'd3);
        check($sformatf("r%0d_foul", idx),   foul,          32'd0);
        check($sformatf("r%0d_best", idx),   best,          r.best);
    endtask

    initial begin
        rounds[0] = '{8,  5,  1'b0, 10'd8, 10'd5,  2'b10, 1'b0, 10'd5};
        rounds[1] = '{6,  6,  1'b0, 10'd6, 10'd6,  2'b01, 1'b1, 10'd5};
        rounds[2] = '{9,  10, 1'b1, 10'd9, 10'd10, 2'b01, 1'b0, 10'd9};
        rounds[3] = '{5,  4,  1'b0, 10'd5, 10'd4,  2'b10, 1'b0, 10'd4};
        rounds[4] = '{7,  8,  1'b1, 10'd7, 10'd8,  2'b01, 1'b0, 10'd4};

        // Power-on reset
        #2 clear = 1'b0;
        step(3);
        check_reset("por");
        @(negedge clk);
        clear = 1'b1;
        step(2);
        check("idle_state", state, 32'd0);

        // Single round and tie
        run_round(0);
        run_round(1);

        // False start by player 0
        begin_round(1'b0);
        press = 2'b01;
        step(3);
        press = 2'b00;
        check("fs_foul",  foul,        32'd1);
        check("fs_res0",  result[9:0], 32'h3FF);
        check("fs_done",  done,        32'd1);
        check("fs_state", state,       32'd1);
        check("fs_go",    go,          32'd0);
        wait_go(lat);
        check("fs_go_latency", lat, 32'd9);
        press_at(2'b10, 4);
        check("fs_state_done", state,         32'd3);
        check("fs_res1",       result[19:10], 32'd4);
        check("fs_res0_hold",  result[9:0],   32'h3FF);
        check("fs_winner",     winner,        32'd2);
        check("fs_winv",       win_valid,     32'd1);
        check("fs_tie",        tie,           32'd0);
        check("fs_foul_hold",  foul,          32'd1);
        check("fs_best",       best,          32'd4);

        // Timeout with no presses; start held high throughout
        begin_round(1'b1);
        wait_go(lat);
        check("to_go_latency", lat, 32'd12);
        step(79);
        check("to_state_pre", state, 32'd2);
        step(1);
        check("to_state",  state,         32'd3);
        check("to_go",     go,            32'd0);
        check("to_res0",   result[9:0],   32'd20);
        check("to_res1",   result[19:10], 32'd20);
        check("to_done",   done,          32'd3);
        check("to_winv",   win_valid,     32'd0);
        check("to_winner", winner,        32'd0);
        check("to_best",   best,          32'd4);
        step(8);
        check("to_held_start", state, 32'd3);
        start = 1'b0;
        step(3);

        // Asynchronous reset in the middle of GO
        begin_round(1'b0);
        wait_go(lat);
        step(10);
        check("mg_go", go, 32'd1);
        #2 clear = 1'b0;
        #1;
        check_reset("midgo");
        @(negedge clk);
        clear = 1'b1;
        step(2);
        check("mg_idle", state, 32'd0);

        // Best tracking across rounds: 9, 4, 7
        run_round(2);
        run_round(3);
        run_round(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_timer_multi.md
Name: reaction_timer_multi

Overview:
- Parametrised multi-player reaction timer; successor to the single-player seconds/ms timer.
- Waits a pseudo-random armed delay, then raises `go` and measures each player's reaction in tick units (ms at default parameters).
- Adds false-start detection, per-player timeout, winner/tie arbitration and best-time tracking across rounds.
- Sits between debounced KEY inputs and the BCD display driver; `go` drives LEDR.

Parameters:
- PLAYERS, 2, number of player press inputs (1..8).
- TICK_DIV, 50000, clk cycles per tick; 50000 gives 1 ms at 50 MHz.
- TIME_W, 10, width of elapsed/result counters.
- TIMEOUT, 999, tick count at which GO phase ends; must be < 2^TIME_W-1.
- MIN_DELAY, 1000, minimum armed delay in ticks.
- DELAY_MASK, 16'h0FFF, mask applied to LFSR to form the random part of the delay.

Ports:
- clk, input, 1, system clock.
- clear, input, 1, asynchronous active-low reset.
- start, input, 1, active-high request to begin a round; asynchronous to clk.
- press, input, PLAYERS, active-high player buttons; asynchronous to clk.
- go, output, 1, high during GO phase.
- state, output, 2, 0=IDLE 1=ARM 2=GO 3=DONE.
- result, output, PLAYERS*TIME_W, per-player reaction time; player p occupies bits [p*TIME_W +: TIME_W].
- done, output, PLAYERS, player has a final result this round.
- foul, output, PLAYERS, player pressed during ARM.
- winner, output, PLAYERS, one-hot fastest valid player.
- win_valid, output, 1, winner is meaningful.
- tie, output, 1, more than one player pressed on the winning cycle.
- best, output, TIME_W, fastest winning time since reset.

Behaviour:
- **Reset** (clear=0, async): state=IDLE, go=0, result=0, done=0, foul=0, winner=0, win_valid=0, tie=0, best=all-ones, LFSR=16'hACE1, prescaler=0. Reset mid-round aborts the round immediately.
- **Input conditioning:** start and each press bit pass through a 2-flop synchroniser plus rising-edge detect, giving a 1-cycle internal pulse 3 clk after the input rises. A held input never retriggers.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11; advances every clk cycle in all states.
- **Tick:** prescaler counts 0..TICK_DIV-1; tick pulses when the count is TICK_DIV-1. The prescaler is forced to 0 on entry to ARM and on entry to GO, so the first tick occurs exactly TICK_DIV cycles after entry.
- **IDLE / DONE:**
  - On a start pulse: go to ARM.
  - Latch delay_cnt = MIN_DELAY + (LFSR & DELAY_MASK).
  - Clear result, done, foul, winner, win_valid, tie. best is retained.
- **ARM:**
  - On each tick, delay_cnt decrements. When a tick arrives with delay_cnt==1, go to GO: set go=1 and elapsed=0.
  - A press pulse from player p with done[p]=0 sets foul[p]=1, done[p]=1, result[p]=all-ones.
  - If all players are done, go to DONE; go is never raised.
  - start pulses are ignored.
- **GO:**
  - On each tick, elapsed increments.
  - A press pulse from player p with done[p]=0 sets result[p]=elapsed (value in that cycle) and done[p]=1.
  - The first cycle with any valid press sets win_valid=1 and winner=lowest-index presser. tie=1 if two or more players pressed in that cycle; in that case all of them get equal results.
  - Later presses record a result but do not change the winner.
  - Exit to DONE (go=0 the next cycle) when all players are done, or on the tick that makes elapsed==TIMEOUT. On timeout, each not-done player gets result=TIMEOUT and done=1.
  - start pulses are ignored.
- **On entry to DONE:** if win_valid and winning time < best, best=winning time. Results hold until the next start pulse.
- **Simultaneous tick and press in the same cycle:** the press captures the pre-increment elapsed.
- **Simultaneous press and timeout tick in the same cycle:** the press wins and records TIMEOUT-1.

Test Plan (TICK_DIV=4, MIN_DELAY=3, DELAY_MASK=0, TIMEOUT=20, PLAYERS=2):
1. Reset check: assert clear mid-GO → all outputs at reset values within the same cycle; state=0; best=10'h3FF.
2. Single round: pulse start; go rises 12 cycles after ARM entry; press[1] after 5 GO ticks → result[1]=5, winner=2'b10, win_valid=1, tie=0; press[0] at tick 8 → result[0]=8; state=3; best=5.
3. False start: press[0] during ARM → foul=2'b01, result[0]=10'h3FF; press[1] at tick 4 → winner=2'b10, result[1]=4.
4. Tie: both press bits rise in the same clk during GO at tick 6 → winner=2'b01, tie=1, both results=6.
5. Timeout: no presses → state=DONE at elapsed 20; result=20,20; win_valid=0; best unchanged.
6. Best tracking: rounds with winning times 9, then 4, then 7 → best=9, 4, 4; start pulses asserted during ARM/GO have no effect.
